// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin request arbiter and its picker.
//   N_REQ   number of request lines
//   IDX_W   width of a request index
//   TCNT_W  width of the grant timeout counter
//   arb_state_e  arbiter FSM state encoding
package arb_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned TCNT_W = 8;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set bit of pend, scanning from ptr upwards with
// wrap-around.
//   pend      pending request bits
//   ptr       index with highest priority
//   pick_oh   one-hot of the selected request, zero when nothing is pending
//   pick_idx  binary index of the selected request, zero when nothing is pending
//   any       at least one request is pending
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] pend,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   rot_idx;

  always_comb begin
    dbl     = {pend, pend};
    // Rotate right by ptr so the highest-priority bit lands at position 0.
    rot     = dbl[ptr +: N_REQ];
    rot_idx = '0;
    any     = 1'b0;
    // Scan downwards so the lowest set bit is the one left standing.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        rot_idx = IDX_W'(i);
        any     = 1'b1;
      end
    end
    // Rotate back; the IDX_W-bit sum wraps modulo N_REQ.
    pick_idx = any ? (rot_idx + ptr) : '0;
    pick_oh  = any ? (N_REQ'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin request arbiter feeding a 4-to-2 encoder. Requests are captured into sticky pending
// bits; one is granted at a time as a registered one-hot vector held until acked or timed out.
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   req          request lines, pulse or level
//   gnt_ack      consumer has taken the current grant
//   gnt          one-hot grant, zero when idle
//   gnt_idx      binary index of gnt, zero when idle
//   gnt_valid    gnt/gnt_idx meaningful
//   pend         pending request bits
//   timeout_err  one-cycle pulse when a grant is force-released
module rr_req_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             gnt_ack,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic [N_REQ-1:0] pend,
  output logic             timeout_err
);

  localparam logic [TCNT_W-1:0] TcntLast = TCNT_W'(TIMEOUT - 1);

  arb_state_e state_q, state_d;

  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              terr_q, terr_d;

  logic              rel;
  logic [N_REQ-1:0]  clr;
  logic [N_REQ-1:0]  pick_pend;
  logic [IDX_W-1:0]  pick_ptr;
  logic [N_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  // Release, pending update and picker inputs.
  always_comb begin
    rel    = (state_q == StGrant) && (gnt_ack || (tcnt_q == TcntLast));
    clr    = rel ? gnt_q : '0;
    // Set wins over clear: a re-request in the release cycle stays pending.
    pend_d = (pend_q & ~clr) | req;
    ptr_d  = rel ? (gnt_idx_q + IDX_W'(1)) : ptr_q;
    // In GRANT the picker only matters on release, where it must see the post-release pending
    // set and the advanced pointer to chain the next grant without a gap.
    if (state_q == StGrant) begin
      pick_pend = pend_d;
      pick_ptr  = gnt_idx_q + IDX_W'(1);
    end else begin
      pick_pend = pend_q;
      pick_ptr  = ptr_q;
    end
  end

  rr_pick u_pick (
    .pend     (pick_pend),
    .ptr      (pick_ptr),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_any) state_d = StGrant;
      StGrant: if (rel && !pick_any) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and timeout counter.
  always_comb begin
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    tcnt_d      = tcnt_q;
    terr_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          gnt_d       = pick_oh;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          tcnt_d      = '0;
        end
      end
      StGrant: begin
        if (rel) begin
          // An ack in the expiry cycle wins, so no error pulse.
          terr_d      = !gnt_ack;
          gnt_d       = pick_oh;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = pick_any;
          tcnt_d      = '0;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      default: begin
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
        tcnt_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      ptr_q       <= '0;
      tcnt_q      <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      ptr_q       <= ptr_d;
      tcnt_q      <= tcnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      terr_q      <= terr_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_idx     = gnt_idx_q;
  assign gnt_valid   = gnt_valid_q;
  assign pend        = pend_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
module tb_rr_req_arbiter;

  localparam int unsigned Timeout = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       gnt_ack;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic [3:0] pend;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;

  // Reference model: pending set, rotating priority, current grant (-1 = none), hold time.
  int m_pend, m_ptr, m_gidx, m_cnt;
  bit m_terr;

  int seq[$];
  int terr_seen;

  always #5 clk = ~clk;

  rr_req_arbiter #(.TIMEOUT(Timeout)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt_ack     (gnt_ack),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .pend        (pend),
    .timeout_err (timeout_err)
  );

  function automatic int pick(int p, int ptr);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (ptr + k) % 4;
      if (p[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_gnt"}, gnt, (m_gidx < 0) ? 4'h0 : 4'(1 << m_gidx));
    check({tag, "_idx"}, {2'b00, gnt_idx}, (m_gidx < 0) ? 4'h0 : 4'(m_gidx));
    check({tag, "_valid"}, {3'b000, gnt_valid}, {3'b000, m_gidx >= 0});
    check({tag, "_pend"}, pend, 4'(m_pend));
    check({tag, "_terr"}, {3'b000, timeout_err}, {3'b000, m_terr});
  endtask

  task automatic model_reset();
    m_pend = 0;
    m_ptr  = 0;
    m_gidx = -1;
    m_cnt  = 0;
    m_terr = 1'b0;
  endtask

  task automatic model_step(input int r, input bit a);
    int  clr;
    int  newp;
    bit  rel;
    clr    = 0;
    rel    = (m_gidx >= 0) && (a || (m_cnt == Timeout - 1));
    m_terr = rel && !a;
    if (rel) begin
      clr   = 1 << m_gidx;
      m_ptr = (m_gidx + 1) % 4;
    end
    newp = (m_pend & ~clr & 15) | r;
    if (m_gidx < 0) begin
      if (m_pend != 0) begin
        m_gidx = pick(m_pend, m_ptr);
        m_cnt  = 0;
      end
    end else if (rel) begin
      m_gidx = pick(newp, m_ptr);
      m_cnt  = 0;
    end else begin
      m_cnt++;
    end
    m_pend = newp;
  endtask

  // One clock: drive inputs away from the edge, advance the model, compare after the edge.
  task automatic step(input logic [3:0] r, input logic a, input string tag);
    req     = r;
    gnt_ack = a;
    @(posedge clk);
    model_step(int'(r), a);
    #1;
    check_all(tag);
  endtask

  // Serve whatever is pending, acking each grant at once, and record the granted indices.
  task automatic serve(input int cycles, input string tag);
    seq.delete();
    for (int i = 0; i < cycles; i++) begin
      step(4'b0000, m_gidx >= 0, tag);
      if (gnt_valid) seq.push_back(int'(gnt_idx));
    end
  endtask

  task automatic check_seq(input string tag, input int e0, input int e1, input int e2,
                           input int e3, input int n);
    int exp[4];
    exp = '{e0, e1, e2, e3};
    check({tag, "_len"}, 4'(seq.size()), 4'(n));
    for (int i = 0; i < n && i < seq.size(); i++) check({tag, "_seq"}, 4'(seq[i]), 4'(exp[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    req     = 4'b0000;
    gnt_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, "idle");

    // Round-robin from ptr=0.
    step(4'b1111, 1'b0, "rr0_req");
    serve(6, "rr0");
    check_seq("rr0", 0, 1, 2, 3, 4);

    // Move ptr to 2, then round-robin again.
    step(4'b0010, 1'b0, "rr2_pre");
    serve(3, "rr2_pre");
    step(4'b1111, 1'b0, "rr2_req");
    serve(6, "rr2");
    check_seq("rr2", 2, 3, 0, 1, 4);

    // Single request: two-edge latency, held until ack.
    step(4'b0100, 1'b0, "single_req");
    check("single_lat", {3'b000, gnt_valid}, 4'h0);
    step(4'b0000, 1'b0, "single_g");
    check("single_gnt", gnt, 4'b0100);
    check("single_idx", {2'b00, gnt_idx}, 4'h2);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, "single_hold");
    step(4'b0000, 1'b1, "single_ack");
    check("single_rel", gnt, 4'b0000);
    check("single_pend", pend, 4'b0000);

    // Set wins over clear on the released bit.
    step(4'b0010, 1'b0, "setwin_req");
    step(4'b0000, 1'b0, "setwin_g");
    step(4'b0101, 1'b0, "setwin_more");
    step(4'b0010, 1'b1, "setwin_ack");
    check("setwin_pend1", {3'b000, pend[1]}, 4'h1);
    seq.delete();
    if (gnt_valid) seq.push_back(int'(gnt_idx));
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, m_gidx >= 0, "setwin_srv");
      if (gnt_valid) seq.push_back(int'(gnt_idx));
    end
    check_seq("setwin", 2, 0, 1, 0, 3);

    // Timeout with no ack.
    terr_seen = 0;
    step(4'b0001, 1'b0, "to_req");
    for (int i = 0; i < 20; i++) begin
      step(4'b0000, 1'b0, "to_wait");
      if (timeout_err) terr_seen++;
    end
    check("to_pulses", 4'(terr_seen), 4'h1);
    check("to_gnt", gnt, 4'b0000);
    check("to_pend", pend, 4'b0000);

    // Ack in the expiry cycle: no timeout error.
    step(4'b0001, 1'b0, "toack_req");
    for (int i = 0; i < 30 && !(m_gidx >= 0 && m_cnt == Timeout - 1); i++) begin
      step(4'b0000, 1'b0, "toack_wait");
    end
    step(4'b0000, 1'b1, "toack_ack");
    check("toack_terr", {3'b000, timeout_err}, 4'h0);
    check("toack_gnt", gnt, 4'b0000);

    // Reset mid-grant: grant idx3 with pend=1011.
    step(4'b0100, 1'b0, "rstg_pre");
    serve(3, "rstg_pre");
    step(4'b1011, 1'b0, "rstg_req");
    step(4'b0000, 1'b0, "rstg_g");
    check("rstg_idx", {2'b00, gnt_idx}, 4'h3);
    check("rstg_pend", pend, 4'b1011);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rstg_async");
    @(posedge clk);
    #1;
    check_all("rstg_hold");
    rst = 1'b0;
    step(4'b1000, 1'b0, "post_req");
    step(4'b0000, 1'b0, "post_g");
    check("post_idx", {2'b00, gnt_idx}, 4'h3);
    step(4'b0000, 1'b1, "post_ack");

    // Post-reset pointer is 0: all four pending grants start at index 0.
    step(4'b1111, 1'b0, "post_rr_req");
    serve(6, "post_rr");
    check_seq("post_rr", 0, 1, 2, 3, 4);

    // Random traffic: frequent acks, then rare acks so timeouts occur.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      logic       a;
      r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if (i < 200) a = ($urandom_range(0, 3) == 0);
      else a = ($urandom_range(0, 19) == 0);
      step(r, a, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
